// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment display that
//   shares a single BCD7 decoder. Each digit slot is DIV cycles long: BLANK
//   dark cycles (anti-ghosting gap) followed by DIV-BLANK lit cycles. The
//   displayed value is double-buffered and only swapped at frame boundaries.
//
//   Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
//   Digit 0 is always lit.
//
// Parameters
//   DIGITS  number of digits scanned (2..8)
//   DIV     clock cycles per digit slot (>= 4)
//   BLANK   dark cycles at the start of each slot (1 <= BLANK < DIV)
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   en     scan enable; 0 forces the display dark and restarts at digit 0
//   load   one-cycle strobe capturing din
//   din    BCD digits, din[3:0] is digit 0 (least significant)
//   bcd    nibble for the shared BCD7 decoder; 4'hF renders dark
//   an     active-low digit enables, at most one low
//   frame  one-cycle pulse on the last cycle of each full scan
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned IW = $clog2(DIGITS);

    localparam logic [TW-1:0] TICK_LAST  = TW'(DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       tick, tick_nxt;
    logic [IW-1:0]       idx, idx_nxt;

    logic [4*DIGITS-1:0] hold;
    logic [4*DIGITS-1:0] disp;
    logic                pend;

    logic                boundary;
    logic                lit;

    // Last lit cycle of the last digit: frame pulse and buffer swap point.
    assign boundary = (state == ST_SHOW) && (tick == TICK_LAST) && (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            tick  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            tick  <= tick_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; tick runs through the whole slot, BLANK and SHOW alike.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        idx_nxt   = idx;
        if (!en) begin
            state_nxt = ST_IDLE;
            tick_nxt  = '0;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    tick_nxt  = '0;
                    idx_nxt   = '0;
                end
                ST_BLANK: begin
                    tick_nxt = tick + 1'b1;
                    if (tick == BLANK_LAST) begin
                        state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (tick == TICK_LAST) begin
                        state_nxt = ST_BLANK;
                        tick_nxt  = '0;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tick_nxt  = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Display double buffer. A load that lands on the swap point or while
    // idle bypasses the capture buffer, since no frame is in progress to tear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            disp <= '0;
            pend <= 1'b0;
        end else begin
            if (load && (boundary || state == ST_IDLE)) begin
                disp <= din;
                pend <= 1'b0;
            end else begin
                if (boundary && pend) begin
                    disp <= hold;
                    pend <= 1'b0;
                end
                if (load) begin
                    hold <= din;
                    pend <= 1'b1;
                end
            end
        end
    end

`ifdef SEG7_LZB_EN
    // lz[k] is set when digit k and every more significant digit are zero.
    logic [DIGITS-1:0] lz;

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz         = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            upper_zero            = upper_zero && (disp[4*(DIGITS-1-k) +: 4] == 4'h0);
            lz[DIGITS-1-k]        = upper_zero;
        end
    end

    assign lit = (idx == '0) || !lz[idx];
`else
    assign lit = 1'b1;
`endif

    // Output decode from registered state only.
    always_comb begin
        an    = '1;
        bcd   = 4'hF;
        frame = boundary;
        if (state == ST_SHOW && lit) begin
            an[idx] = 1'b0;
            bcd     = disp[4*idx +: 4];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK     = 2;
    localparam int FRAME_LEN = DIGITS * DIV;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .din   (din),
        .bcd   (bcd),
        .an    (an),
        .frame (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: scan position is a plain cycle count since the scan
    // started; slot, offset and frame follow by division.
    bit          m_on;
    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_hold;
    bit          m_pend;
    bit          m_bnd;

    assign m_bnd = m_on && ((m_pos % FRAME_LEN) == FRAME_LEN - 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on   <= 1'b0;
            m_pos  <= 0;
            m_disp <= '0;
            m_hold <= '0;
            m_pend <= 1'b0;
        end else begin
            if (load && (m_bnd || !m_on)) begin
                m_disp <= din;
                m_pend <= 1'b0;
            end else begin
                if (m_bnd && m_pend) begin
                    m_disp <= m_hold;
                    m_pend <= 1'b0;
                end
                if (load) begin
                    m_hold <= din;
                    m_pend <= 1'b1;
                end
            end
            if (!en) begin
                m_on  <= 1'b0;
                m_pos <= 0;
            end else if (!m_on) begin
                m_on  <= 1'b1;
                m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    logic [3:0] exp_an;
    logic [3:0] exp_bcd;
    logic       exp_frame;
    int         m_t;
    int         m_s;
    bit         m_lit;

    always_comb begin
        exp_an    = 4'hF;
        exp_bcd   = 4'hF;
        exp_frame = 1'b0;
        m_t       = 0;
        m_s       = 0;
        m_lit     = 1'b0;
        if (m_on) begin
            m_t       = m_pos % DIV;
            m_s       = (m_pos / DIV) % DIGITS;
            exp_frame = (m_t == DIV - 1) && (m_s == DIGITS - 1);
            m_lit     = (m_t >= BLANK);
`ifdef SEG7_LZB_EN
            if (m_s > 0 && (m_disp >> (4 * m_s)) == 16'h0) m_lit = 1'b0;
`endif
            if (m_lit) begin
                exp_an  = ~(4'b0001 << m_s);
                exp_bcd = m_disp[4*m_s +: 4];
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        din  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL reset_an got %b want 1111", an);
        end
        checks++;
        if (bcd !== 4'hF) begin
            errors++;
            $display("FAIL reset_bcd got %h want f", bcd);
        end
        checks++;
        if (frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame got %b want 0", frame);
        end
        checks++;
        if (dut.pend !== 1'b0 || dut.disp !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs pend=%b disp=%h want 0/0000", dut.pend, dut.disp);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_frame();
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL first_frame c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (c == 2) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL first_blank an=%b want 1111", an);
                end
            end
            if (c == 3) begin
                checks++;
                if (an !== 4'b1110 || bcd !== 4'h0) begin
                    errors++;
                    $display("FAIL first_lit an=%b bcd=%h want 1110/0", an, bcd);
                end
            end
            if (c == 32) begin
                checks++;
                if (frame !== 1'b1) begin
                    errors++;
                    $display("FAIL first_frame_pulse frame=%b want 1", frame);
                end
            end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_idle();
        logic [3:0] ean [4];
        logic [3:0] ebcd [4];
        ean[0] = 4'b1110; ebcd[0] = 4'h4;
        ean[1] = 4'b1101; ebcd[1] = 4'h3;
        ean[2] = 4'b1011; ebcd[2] = 4'h2;
        ean[3] = 4'b0111; ebcd[3] = 4'h1;
        din  = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL load_idle c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (c >= 3 && (c - 3) % DIV == 0 && (c - 3) / DIV < 4) begin
                checks++;
                if (an !== ean[(c-3)/DIV] || bcd !== ebcd[(c-3)/DIV]) begin
                    errors++;
                    $display("FAIL load_idle_digit c=%0d an=%b bcd=%h want %b/%h",
                             c, an, bcd, ean[(c-3)/DIV], ebcd[(c-3)/DIV]);
                end
            end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_midframe_load();
        logic [3:0] want;
        en = 1'b1;
        for (int c = 0; c < 72; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL midframe c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            want = 4'hF;
            case (c)
                19: want = 4'h2;
                27: want = 4'h1;
                35: want = 4'h8;
                43: want = 4'h7;
                51: want = 4'h6;
                59: want = 4'h5;
                default: want = 4'hF;
            endcase
            if (want != 4'hF) begin
                checks++;
                if (bcd !== want) begin
                    errors++;
                    $display("FAIL midframe_digit c=%0d bcd=%h want %h", c, bcd, want);
                end
            end
            if (c == 20) begin
                checks++;
                if (dut.pend !== 1'b1) begin
                    errors++;
                    $display("FAIL midframe_pend pend=%b want 1", dut.pend);
                end
            end
            load = (c == 11);
            if (c == 11) din = 16'h5678;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_load_on_frame();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 2 * FRAME_LEN && !found; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL frame_wait c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (frame === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_timeout frame=%b want 1 within %0d cycles", frame, 2 * FRAME_LEN);
        end else begin
            din  = 16'h9ABC;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int c = 1; c < 20; c++) begin
                checks++;
                if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                    errors++;
                    $display("FAIL load_on_frame c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                             c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
                end
                if (c == 1) begin
                    checks++;
                    if (dut.pend !== 1'b0 || dut.disp !== 16'h9ABC) begin
                        errors++;
                        $display("FAIL load_on_frame_direct pend=%b disp=%h want 0/9abc", dut.pend, dut.disp);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if (an !== 4'b1110 || bcd !== 4'hC) begin
                        errors++;
                        $display("FAIL load_on_frame_slot0 an=%b bcd=%h want 1110/c", an, bcd);
                    end
                end
                if (c == 11) begin
                    checks++;
                    if (an !== 4'b1101 || bcd !== 4'hB) begin
                        errors++;
                        $display("FAIL load_on_frame_slot1 an=%b bcd=%h want 1101/b", an, bcd);
                    end
                end
                @(negedge clk);
            end
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_en_drop();
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL en_drop c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (c == 21) begin
                checks++;
                if (an !== 4'b1011 || bcd !== 4'hA) begin
                    errors++;
                    $display("FAIL en_drop_slot2 an=%b bcd=%h want 1011/a", an, bcd);
                end
            end
            if (c == 22 || c == 24) begin
                checks++;
                if (an !== 4'b1111 || bcd !== 4'hF) begin
                    errors++;
                    $display("FAIL en_drop_dark c=%0d an=%b bcd=%h want 1111/f", c, an, bcd);
                end
            end
            if (c == 25) begin
                checks++;
                if (an !== 4'b1110 || bcd !== 4'hC) begin
                    errors++;
                    $display("FAIL en_resume an=%b bcd=%h want 1110/c", an, bcd);
                end
            end
            en = (c != 21);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL pre_rst c=%0d an=%b want %b bcd=%h want %h", c, an, exp_an, bcd, exp_bcd);
            end
            if (c < 3) @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || bcd !== 4'hF || frame !== 1'b0) begin
            errors++;
            $display("FAIL async_rst an=%b bcd=%h frame=%b want 1111/f/0", an, bcd, frame);
        end
        #1;
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL post_rst c=%0d an=%b want %b bcd=%h want %h", c, an, exp_an, bcd, exp_bcd);
            end
            if (c == 3) begin
                checks++;
                if (an !== 4'b1110 || bcd !== 4'h0) begin
                    errors++;
                    $display("FAIL post_rst_cleared an=%b bcd=%h want 1110/0", an, bcd);
                end
            end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lzb();
        logic [3:0] hi_an2;
        logic [3:0] hi_an3;
        logic [3:0] hi_an1;
        logic [3:0] hi_bcd;
`ifdef SEG7_LZB_EN
        hi_an2 = 4'b1111; hi_an3 = 4'b1111; hi_an1 = 4'b1111; hi_bcd = 4'hF;
`else
        hi_an2 = 4'b1011; hi_an3 = 4'b0111; hi_an1 = 4'b1101; hi_bcd = 4'h0;
`endif
        din  = 16'h0050;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        for (int c = 0; c < 34; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL lzb_0050 c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (c == 3 || c == 11 || c == 19 || c == 27) begin
                logic [3:0] wa;
                logic [3:0] wb;
                wa = 4'b1110; wb = 4'h0;
                if (c == 11) begin wa = 4'b1101; wb = 4'h5; end
                if (c == 19) begin wa = hi_an2;  wb = hi_bcd; end
                if (c == 27) begin wa = hi_an3;  wb = hi_bcd; end
                checks++;
                if (an !== wa || bcd !== wb) begin
                    errors++;
                    $display("FAIL lzb_0050_digit c=%0d an=%b bcd=%h want %b/%h", c, an, bcd, wa, wb);
                end
            end
            @(negedge clk);
        end
        en   = 1'b0;
        @(negedge clk);
        din  = 16'h0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        for (int c = 0; c < 34; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL lzb_0000 c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            if (c == 3) begin
                checks++;
                if (an !== 4'b1110 || bcd !== 4'h0) begin
                    errors++;
                    $display("FAIL lzb_zero_digit0 an=%b bcd=%h want 1110/0", an, bcd);
                end
            end
            if (c == 11) begin
                checks++;
                if (an !== hi_an1 || bcd !== hi_bcd) begin
                    errors++;
                    $display("FAIL lzb_zero_digit1 an=%b bcd=%h want %b/%h", an, bcd, hi_an1, hi_bcd);
                end
            end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || frame !== exp_frame) begin
                errors++;
                $display("FAIL random c=%0d an=%b want %b bcd=%h want %h frame=%b want %b",
                         c, an, exp_an, bcd, exp_bcd, frame, exp_frame);
            end
            en   = ($urandom_range(0, 39) != 0);
            load = ($urandom_range(0, 7) == 0);
            din  = 16'($urandom);
            @(negedge clk);
        end
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        din  = '0;
        test_reset();
        test_first_frame();
        test_load_idle();
        test_midframe_load();
        test_load_on_frame();
        test_en_drop();
        test_async_reset();
        test_lzb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
